// File: rtl/counter_trigger_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_trigger_pkg - shared state/source encodings for the trigger gen  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package counter_trigger_pkg;

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_COUNTING = 2'd2;
    localparam logic [1:0] ST_FIRED    = 2'd3;

    localparam logic SRC_CLK = 1'b0;
    localparam logic SRC_REF = 1'b1;

    // Trigger is high when disabled so the downstream AND stays transparent.
    function automatic logic trigger_level(input logic [1:0] st);
        return (st == ST_DISABLED) || (st == ST_FIRED);
    endfunction

endpackage : counter_trigger_pkg
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_edge_detect - multi-stage synchronizer plus registered rise strobe  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic aresetn,
    input  logic d_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   rise_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            last_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

    assign rise = rise_q;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/counter_trigger_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_trigger_gen - armed event counter producing the reset trigger    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module counter_trigger_gen
    import counter_trigger_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  logic                   arm,
    input  logic                   source_sel,
    input  logic [COUNT_WIDTH-1:0] preset,
    input  logic                   ref_in,
    output logic                   counter_trigger,
    output logic                   fired_pulse,
    output logic [1:0]             state_sts,
    output logic [COUNT_WIDTH-1:0] count_sts
);

    localparam logic [COUNT_WIDTH-1:0] C_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic                   arm_q, arm_prev_q;
    logic [1:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] preset_q, preset_d;
    logic                   trig_q, pulse_q, pulse_d;
    logic                   ref_evt;
    logic                   arm_rise, arm_fall, ev;
    logic [COUNT_WIDTH-1:0] count_inc;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ref_sync (
        .clk     (clk),
        .aresetn (aresetn),
        .d_async (ref_in),
        .rise    (ref_evt)
    );

    // arm is registered first, so edges are detected between two sampled copies.
    assign arm_rise  = arm_q & ~arm_prev_q;
    assign arm_fall  = ~arm_q & arm_prev_q;
    assign ev        = (source_sel == SRC_REF) ? ref_evt : 1'b1;
    assign count_inc = count_q + C_ONE;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_q;
        pulse_d  = 1'b0;
        if (!enable) begin
            state_d = ST_DISABLED;
            count_d = '0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
                ST_IDLE: begin
                    count_d = '0;
                    if (arm_rise) begin
                        preset_d = preset;
                        if (preset == '0) begin
                            state_d = ST_FIRED;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = ST_COUNTING;
                        end
                    end
                end
                ST_COUNTING: begin
                    if (arm_fall) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else if (ev) begin
                        count_d = count_inc;
                        if (count_inc == preset_q) begin
                            state_d = ST_FIRED;
                            pulse_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (arm_fall) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            arm_q      <= 1'b0;
            arm_prev_q <= 1'b0;
            state_q    <= ST_DISABLED;
            count_q    <= '0;
            preset_q   <= '0;
            trig_q     <= 1'b1;
            pulse_q    <= 1'b0;
        end else begin
            arm_q      <= arm;
            arm_prev_q <= arm_q;
            state_q    <= state_d;
            count_q    <= count_d;
            preset_q   <= preset_d;
            trig_q     <= trigger_level(state_d);
            pulse_q    <= pulse_d;
        end
    end

    assign counter_trigger = trig_q;
    assign fired_pulse     = pulse_q;
    assign state_sts       = state_q;
    assign count_sts       = count_q;

endmodule : counter_trigger_gen
`default_nettype wire
